// File: rtl/alu_cmd_issuer_if.sv
// Host command/response and ALU drive bundle for alu_cmd_issuer.
// master = the issuer; slave = the host plus the ALU it drives.
interface alu_cmd_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [2:0]               cmd_op;
    logic [3:0]               cmd_a;
    logic [3:0]               cmd_b;
    logic [TAG_W-1:0]         cmd_tag;
    logic                     cmd_chain;
    logic [2:0]               alu_op;
    logic [3:0]               alu_a;
    logic [3:0]               alu_b;
    logic [3:0]               alu_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [3:0]               rsp_data;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     rsp_err;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, cmd_chain, alu_result, rsp_ready,
        output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_tag, rsp_err,
               fifo_level, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, cmd_chain, alu_result, rsp_ready,
        input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_tag, rsp_err,
               fifo_level, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// FIFO-buffered ALU command issuer: pop -> ISSUE -> WAIT(ALU_LAT) -> RESP, 4 cycles/legal cmd.
// Response held until rsp_ready; cmd_ready = !full. Macro ALU_CHAIN_EN feeds last result into alu_a.
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2,
    parameter int ALU_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    alu_cmd_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef struct packed {
        logic [2:0]       op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
        logic             chain;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      level;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic [3:0]       op_a;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       alu_op_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [3:0]       rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_err_q;

    assign cmd_in  = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b,
                       tag: bus.cmd_tag, chain: bus.cmd_chain};
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push    = bus.cmd_valid && !full;
    assign pop     = (state_q == IDLE) && !empty;
    assign capture = (state_q == WAIT) && (cnt_q == '0);

`ifdef ALU_CHAIN_EN
    logic [3:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst)          chain_q <= '0;
        else if (capture) chain_q <= bus.alu_result;
    end

    assign op_a = head.chain ? chain_q : head.a;
`else
    logic unused_chain;

    assign unused_chain = head.chain;
    assign op_a         = head.a;
`endif

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    rsp_tag_q <= head.tag;
                    if (head.op <= 3'd4) begin
                        alu_op_q <= head.op;
                        alu_a_q  <= op_a;
                        alu_b_q  <= head.b;
                        state_q  <= ISSUE;
                    end else begin
                        // Illegal op never reaches the ALU; answer directly.
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CW'(ALU_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        rsp_data_q <= bus.alu_result;
                        rsp_err_q  <= 1'b0;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.fifo_level = level;
    assign bus.busy       = (state_q != IDLE);
endmodule
